alu_issue_ctrl: RTL and testbench

Issue sequencer between the decode stage and the ALU. It accepts one decoded micro-op at a time through a valid/ready handshake and holds its operands stable. It drives the ALU enable/opcode/operand inputs and enforces three timing rules: a multi-cycle multiply window, a hold while memory is blocked, and a one-cycle bubble after branch-class ops so a redirect lands before the next issue. It also keeps saturating issue and stall counters for performance debug.

---
 rtl/alu_issue_ctrl.sv | 143 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue sequencer between decode and the ALU: holds one micro-op, enforces the
// multiply window, memory-stall hold and post-branch bubble, and counts issues/stalls.
module alu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dec_valid,
  output logic             dec_ready,
  input  logic [9:0]       dec_opcode,
  input  logic [63:0]      dec_oprd1,
  input  logic [63:0]      dec_oprd2,
  input  logic [63:0]      dec_oprd3,
  input  logic [63:0]      dec_next_rip,
  output logic             alu_enable,
  output logic [9:0]       alu_opcode,
  output logic [63:0]      alu_oprd1,
  output logic [63:0]      alu_oprd2,
  output logic [63:0]      alu_oprd3,
  output logic [63:0]      alu_next_rip,
  input  logic             mem_blocked,
  output logic             busy,
  output logic [CNT_W-1:0] issue_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    ISSUE    = 2'd2,
    BR_WAIT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [3:0]       MUL_LOAD = 4'(MUL_LAT - 32'd1);
  localparam logic             MUL_EXTRA = (MUL_LAT > 32'd1);

  function automatic logic is_mul(input logic [9:0] op);
    return (op == 10'h0F7) || (op == 10'h1AF);
  endfunction

  function automatic logic is_br(input logic [9:0] op);
    return ((op >= 10'h070) && (op <= 10'h07F)) || (op == 10'h0E9) ||
           (op == 10'h0EB) || ((op >= 10'h180) && (op <= 10'h18F));
  endfunction

  state_t      state_r, state_s;
  logic [3:0]  mul_cnt_r;
  logic [9:0]  opcode_r;
  logic [63:0] oprd1_r, oprd2_r, oprd3_r, next_rip_r;
  logic [CNT_W-1:0] issue_cnt_r, stall_cnt_r;
  logic        ready_s, capture_s, complete_s, stall_s;

  // Handshake and event decode; ready deliberately ignores dec_valid.
  always_comb begin
    ready_s    = (state_r == IDLE) ||
                 ((state_r == ISSUE) && !mem_blocked && !is_br(opcode_r));
    capture_s  = dec_valid && ready_s;
    complete_s = (state_r == ISSUE) && !mem_blocked;
    stall_s    = (state_r == ISSUE) && mem_blocked;
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (capture_s) state_s = (is_mul(dec_opcode) && MUL_EXTRA) ? MUL_WAIT : ISSUE;
        else           state_s = IDLE;
      end
      MUL_WAIT: begin
        if (mul_cnt_r == 4'd1) state_s = ISSUE;
        else                   state_s = MUL_WAIT;
      end
      ISSUE: begin
        if (mem_blocked)        state_s = ISSUE;
        else if (is_br(opcode_r)) state_s = BR_WAIT;
        else if (capture_s)     state_s = (is_mul(dec_opcode) && MUL_EXTRA) ? MUL_WAIT : ISSUE;
        else                    state_s = IDLE;
      end
      BR_WAIT: state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, multiply window and captured operand registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      mul_cnt_r  <= 4'd0;
      opcode_r   <= 10'd0;
      oprd1_r    <= 64'd0;
      oprd2_r    <= 64'd0;
      oprd3_r    <= 64'd0;
      next_rip_r <= 64'd0;
    end else begin
      state_r <= state_s;
      if (capture_s && is_mul(dec_opcode) && MUL_EXTRA) mul_cnt_r <= MUL_LOAD;
      else if ((state_r == MUL_WAIT) && (mul_cnt_r != 4'd0)) mul_cnt_r <= mul_cnt_r - 4'd1;
      else mul_cnt_r <= mul_cnt_r;
      if (capture_s) begin
        opcode_r   <= dec_opcode;
        oprd1_r    <= dec_oprd1;
        oprd2_r    <= dec_oprd2;
        oprd3_r    <= dec_oprd3;
        next_rip_r <= dec_next_rip;
      end else begin
        opcode_r   <= opcode_r;
        oprd1_r    <= oprd1_r;
        oprd2_r    <= oprd2_r;
        oprd3_r    <= oprd3_r;
        next_rip_r <= next_rip_r;
      end
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issue_cnt_r <= {CNT_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (complete_s && (issue_cnt_r != CNT_MAX)) issue_cnt_r <= issue_cnt_r + CNT_ONE;
      else                                        issue_cnt_r <= issue_cnt_r;
      if (stall_s && (stall_cnt_r != CNT_MAX)) stall_cnt_r <= stall_cnt_r + CNT_ONE;
      else                                     stall_cnt_r <= stall_cnt_r;
    end
  end

  assign dec_ready    = ready_s;
  assign alu_enable   = (state_r == ISSUE);
  assign busy         = (state_r != IDLE);
  assign alu_opcode   = opcode_r;
  assign alu_oprd1    = oprd1_r;
  assign alu_oprd2    = oprd2_r;
  assign alu_oprd3    = oprd3_r;
  assign alu_next_rip = next_rip_r;
  assign issue_cnt    = issue_cnt_r;
  assign stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: instance A (MUL_LAT=3, 32-bit counters) and
// instance B (MUL_LAT=1, 3-bit counters for saturation), selected by sel.
module tb_alu_issue_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sel = 1'b0;
  logic dv = 1'b0, mb = 1'b0;
  logic [9:0]  op = 10'd0;
  logic [63:0] o1 = 64'd0, o2 = 64'd0, o3 = 64'd0, rip = 64'd0;

  logic a_rdy, a_en, a_bsy, b_rdy, b_en, b_bsy;
  logic [9:0]  a_op, b_op;
  logic [63:0] a_o1, a_o2, a_o3, a_rip, b_o1, b_o2, b_o3, b_rip;
  logic [31:0] a_ic, a_sc;
  logic [2:0]  b_ic, b_sc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.MUL_LAT(3), .CNT_W(32)) u_a (
    .clk(clk), .reset_n(reset_n), .dec_valid(dv & ~sel), .dec_ready(a_rdy),
    .dec_opcode(op), .dec_oprd1(o1), .dec_oprd2(o2), .dec_oprd3(o3), .dec_next_rip(rip),
    .alu_enable(a_en), .alu_opcode(a_op), .alu_oprd1(a_o1), .alu_oprd2(a_o2),
    .alu_oprd3(a_o3), .alu_next_rip(a_rip), .mem_blocked(mb & ~sel), .busy(a_bsy),
    .issue_cnt(a_ic), .stall_cnt(a_sc));

  alu_issue_ctrl #(.MUL_LAT(1), .CNT_W(3)) u_b (
    .clk(clk), .reset_n(reset_n), .dec_valid(dv & sel), .dec_ready(b_rdy),
    .dec_opcode(op), .dec_oprd1(o1), .dec_oprd2(o2), .dec_oprd3(o3), .dec_next_rip(rip),
    .alu_enable(b_en), .alu_opcode(b_op), .alu_oprd1(b_o1), .alu_oprd2(b_o2),
    .alu_oprd3(b_o3), .alu_next_rip(b_rip), .mem_blocked(mb & sel), .busy(b_bsy),
    .issue_cnt(b_ic), .stall_cnt(b_sc));

  wire        en  = sel ? b_en  : a_en;
  wire        rdy = sel ? b_rdy : a_rdy;
  wire        bsy = sel ? b_bsy : a_bsy;
  wire [9:0]  aop = sel ? b_op  : a_op;
  wire [63:0] a1  = sel ? b_o1  : a_o1;
  wire [63:0] a2  = sel ? b_o2  : a_o2;
  wire [31:0] ic  = sel ? {29'd0, b_ic} : a_ic;
  wire [31:0] sc  = sel ? {29'd0, b_sc} : a_sc;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  logic [9:0] br_ops [6];
  logic       br_exp [6];

  initial begin
    br_ops = '{10'h070, 10'h07F, 10'h18F, 10'h080, 10'h0EB, 10'h1F7};
    br_exp = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // reset state
    #12;
    check("rst_en", {63'd0, en}, 64'd0);
    check("rst_busy", {63'd0, bsy}, 64'd0);
    check("rst_rdy", {63'd0, rdy}, 64'd1);
    check("rst_op", {54'd0, aop}, 64'd0);
    check("rst_o1", a1, 64'd0);
    check("rst_ic", {32'd0, ic}, 64'd0);
    check("rst_sc", {32'd0, sc}, 64'd0);
    #1 reset_n = 1'b1;
    tick();

    // back-to-back ADD/SUB
    dv = 1'b1; op = 10'h000; o1 = 64'd1; o2 = 64'd2;
    smp(); check("b2b_rdy0", {63'd0, rdy}, 64'd1);
    tick();
    op = 10'h028; o1 = 64'd5; o2 = 64'd3;
    smp();
    check("b2b_en1", {63'd0, en}, 64'd1);
    check("b2b_op1", {54'd0, aop}, 64'h000);
    check("b2b_a1", a1, 64'd1);
    check("b2b_a2", a2, 64'd2);
    check("b2b_rdy1", {63'd0, rdy}, 64'd1);
    tick();
    dv = 1'b0;
    smp();
    check("b2b_en2", {63'd0, en}, 64'd1);
    check("b2b_op2", {54'd0, aop}, 64'h028);
    check("b2b_b1", a1, 64'd5);
    check("b2b_b2", a2, 64'd3);
    check("b2b_rdy2", {63'd0, rdy}, 64'd1);
    tick(); smp();
    check("b2b_idle_en", {63'd0, en}, 64'd0);
    check("b2b_ic", {32'd0, ic}, 64'd2);

    // IMUL with MUL_LAT=3
    tick();
    dv = 1'b1; op = 10'h1AF; o1 = 64'd7; o2 = 64'd6;
    tick();
    dv = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      smp();
      check("mul_wait_en", {63'd0, en}, 64'd0);
      check("mul_wait_rdy", {63'd0, rdy}, 64'd0);
      check("mul_wait_busy", {63'd0, bsy}, 64'd1);
      tick();
    end
    smp();
    check("mul_issue_en", {63'd0, en}, 64'd1);
    check("mul_issue_a1", a1, 64'd7);
    tick(); smp();
    check("mul_done_en", {63'd0, en}, 64'd0);
    check("mul_ic", {32'd0, ic}, 64'd3);

    // memory stall for 4 cycles
    tick();
    dv = 1'b1; op = 10'h0B8; o1 = 64'hAAAA;
    tick();
    dv = 1'b0; mb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      smp();
      check("stall_en", {63'd0, en}, 64'd1);
      check("stall_rdy", {63'd0, rdy}, 64'd0);
      check("stall_a1", a1, 64'hAAAA);
      tick();
    end
    mb = 1'b0;
    smp();
    check("stall_last_en", {63'd0, en}, 64'd1);
    check("stall_last_rdy", {63'd0, rdy}, 64'd1);
    tick(); smp();
    check("stall_sc", {32'd0, sc}, 64'd4);
    check("stall_ic", {32'd0, ic}, 64'd4);
    check("stall_idle_en", {63'd0, en}, 64'd0);

    // branch bubble: 0x0E9 then a held-valid 0x000
    tick();
    dv = 1'b1; op = 10'h0E9;
    tick();
    op = 10'h000;
    smp();
    check("br_en0", {63'd0, en}, 64'd1);
    check("br_rdy0", {63'd0, rdy}, 64'd0);
    tick(); smp();
    check("br_en1", {63'd0, en}, 64'd0);
    check("br_rdy1", {63'd0, rdy}, 64'd0);
    check("br_op_held", {54'd0, aop}, 64'h0E9);
    tick(); smp();
    check("br_en2", {63'd0, en}, 64'd0);
    check("br_rdy2", {63'd0, rdy}, 64'd1);
    tick();
    dv = 1'b0;
    smp();
    check("br_en3", {63'd0, en}, 64'd1);
    check("br_op3", {54'd0, aop}, 64'h000);
    tick(); smp();
    check("br_ic", {32'd0, ic}, 64'd6);

    // asynchronous reset during MUL_WAIT
    tick();
    dv = 1'b1; op = 10'h0F7; o1 = 64'd9;
    tick();
    dv = 1'b0;
    smp();
    check("rmul_busy", {63'd0, bsy}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rmul_busy0", {63'd0, bsy}, 64'd0);
    check("rmul_en0", {63'd0, en}, 64'd0);
    check("rmul_op0", {54'd0, aop}, 64'd0);
    check("rmul_a1", a1, 64'd0);
    check("rmul_ic", {32'd0, ic}, 64'd0);
    #1 reset_n = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      smp();
      check("rmul_no_issue", {63'd0, en}, 64'd0);
      tick();
    end

    // opcode class boundaries
    for (int i = 0; i < 6; i++) begin
      dv = 1'b1; op = br_ops[i];
      tick();
      dv = 1'b0;
      smp();
      check("cls_en", {63'd0, en}, 64'd1);
      check("cls_rdy", {63'd0, rdy}, {63'd0, ~br_exp[i]});
      tick();
      if (br_exp[i]) tick();
    end

    // instance B: IMUL with MUL_LAT=1
    sel = 1'b1;
    dv = 1'b1; op = 10'h1AF; o1 = 64'd3;
    smp(); check("mul1_rdy", {63'd0, rdy}, 64'd1);
    tick();
    dv = 1'b0;
    smp();
    check("mul1_en", {63'd0, en}, 64'd1);
    check("mul1_op", {54'd0, aop}, 64'h1AF);
    tick(); smp();
    check("mul1_done_en", {63'd0, en}, 64'd0);

    // instance B: stall counter saturation at 3'b111
    tick();
    dv = 1'b1; op = 10'h0B8;
    tick();
    dv = 1'b0; mb = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    smp(); check("sat_sc6", {32'd0, sc}, 64'd6);
    for (int i = 0; i < 3; i++) begin
      tick(); smp();
      check("sat_sc7", {32'd0, sc}, 64'd7);
    end
    mb = 1'b0;
    tick(); smp();
    check("sat_hold", {32'd0, sc}, 64'd7);
    check("sat_ic", {32'd0, ic}, 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
